color_dealer: RTL
=================

# color_dealer

Parametrised, clocked colour generator for the colour-match game. On request it draws one non-black ball colour and NUM_PLATS platform colours from an internal LFSR, forces exactly one randomly chosen platform to carry the ball colour, and presents the set with a level valid flag. It sits between the game-control FSM, which raises req at each new round, and the platform/ball renderers, which latch the outputs while valid is high.

## Interface
- COLOR_W, 3: bits per colour; colour 0 is black and is never emitted by a draw.
- NUM_PLATS, 4: number of platforms, 2..16.
- LFSR_W, 16: LFSR width; legal values are 8, 16 and 32.
- SEED, 16'hACE1: LFSR reset value and zero-seed substitute; must be non-zero.
- RETRY_MAX, 4: maximum rejected draws per slot before the fallback colour is used.
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  start a new deal; sampled only in IDLE.
- seed_load  in  1  load seed_in into the LFSR this cycle.
- seed_in  in  LFSR_W  new seed; a value of 0 loads SEED instead.
- busy  out  1  high while a deal is in progress.
- valid  out  1  outputs hold a complete deal.
- ball_color  out  COLOR_W  ball colour.
- plat_colors  out  NUM_PLATS*COLOR_W  platform k is at bits [k*COLOR_W +: COLOR_W].
- match_idx  out  IDX_W  index of the platform that equals ball_color; IDX_W = max(1, $clog2(NUM_PLATS)).

## Operation
- Reset: state IDLE, busy 0, valid 0, ball_color 0, plat_colors 0, match_idx 0, LFSR = SEED, retry counter 0, slot counter 0.
- LFSR: Galois, maximal-length, free-running (advances every cycle in every state). seed_load overrides the advance for that cycle. Candidate colour = LFSR[COLOR_W-1:0] of the current cycle.
- Fallback colour: 2 if ball_color == 1, else 1.
- IDLE: busy 0. req=1 -> clear valid, go to BALL.
- BALL: accept the candidate if it is non-zero. If the candidate is 0 and retry < RETRY_MAX, increment retry and stay. If the candidate is 0 and retry == RETRY_MAX, take 1. On accept, clear retry, set slot = 0, go to PLATS.
- PLATS: one slot per cycle. A candidate is acceptable if it is non-zero; with DISTINCT_COLORS_EN it must also differ from ball_color. Rejection and retry rules are the same as BALL; when retries are exhausted, take the fallback colour. Write the accepted colour to slot `slot`. After slot NUM_PLATS-1, go to PLACE.
- PLACE: idx = LFSR[IDX_W-1:0]; if idx >= NUM_PLATS, subtract NUM_PLATS once. Write ball_color into that slot and set match_idx = idx. Set valid 1 and go to IDLE.
- Outputs change only in BALL, PLATS and PLACE. While valid is 1, outputs are stable.
- req while busy is ignored and not queued.
- seed_load while busy is honoured; the deal continues from the new state.
- Reset asserted mid-deal abandons the deal and returns all outputs to their reset values.

## Timing
- busy = (state != IDLE), decoded from registered state.
- With no rejections, valid rises NUM_PLATS+2 edges after the edge that samples req. Default parameters: 6 cycles.
- Worst case: NUM_PLATS+2 + (NUM_PLATS+1)*RETRY_MAX edges. Default parameters: 26 cycles.
- If req=1 in the IDLE cycle where valid=1, the request is accepted and valid falls on the next edge.
- valid stays high until the next accepted req or reset.

## Configuration
- DISTINCT_COLORS_EN defined: decoy platforms never equal ball_color, so match_idx is the only matching platform.
- DISTINCT_COLORS_EN undefined: decoys only need to be non-black and may duplicate ball_color.

## Structure
- color_dealer_pkg: state enum (IDLE, BALL, PLATS, PLACE), LFSR tap constants for widths 8, 16 and 32, and a fallback_color function.
- Sub-module lfsr_gen: parameters LFSR_W and SEED; ports clk, reset, load, load_val, q. Zero-seed substitution is done inside lfsr_gen.
- The FSM, retry and slot counters, and the output registers live in color_dealer.

## Test plan
- Reset mid-deal: assert reset in PLATS -> all outputs 0 and busy 0 in the same cycle; LFSR reads 16'hACE1 after release.
- Default parameters, 1000 reqs: every deal has ball_color != 0, all plat slots != 0, and slot match_idx == ball_color. Any deal with no rejections has valid exactly 6 cycles after req.
- Zero seed: seed_load=1 with seed_in=0 -> LFSR = 16'hACE1. Two runs from identical seed and req timing produce identical deals.
- RETRY_MAX=0, COLOR_W=1: every slot is either 1 or the fallback colour. With DISTINCT_COLORS_EN the fallback is 2 (illegal in 1 bit), so expect a compile-time assertion failure. Use COLOR_W=2: ball 1 -> decoys 2 or 3.
- NUM_PLATS=3: match_idx is always in 0..2 and an LFSR low-bits value of 3 maps to 0. With DISTINCT_COLORS_EN, exactly one slot equals ball_color.
- req held high across a deal -> no restart while busy. The next deal starts in the IDLE cycle where valid=1, and valid falls on the following edge.

Source files
------------

// File: rtl/color_dealer_pkg.sv
// color_dealer_pkg: FSM state type, Galois LFSR tap masks and the fallback colour helper
package color_dealer_pkg;

    typedef enum logic [1:0] {IDLE, BALL, PLATS, PLACE} state_e;

    // Right-shift Galois masks for maximal-length sequences
    localparam logic [31:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_16 = 32'h0000_B400;
    localparam logic [31:0] TAPS_32 = 32'h8020_0003;

    function automatic logic [31:0] lfsr_taps(input int w);
        return w == 8 ? TAPS_8 : w == 16 ? TAPS_16 : TAPS_32;
    endfunction

    function automatic logic [31:0] fallback_color(input logic [31:0] ball);
        return ball == 32'd1 ? 32'd2 : 32'd1;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// lfsr_gen: free-running Galois LFSR with synchronous load.
//   clk, reset (async, active-high) | load, load_val: replace state this cycle,
//   a zero load_val loads SEED instead | q: current LFSR state
module lfsr_gen import color_dealer_pkg::*; #(
    parameter int LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

    logic [LFSR_W-1:0] q_q, q_d;

    // An all-zero state would lock the LFSR, so a zero load falls back to SEED
    always_comb q_d = load ? (load_val == '0 ? SEED : load_val)
                           : (q_q >> 1) ^ (q_q[0] ? TAPS : '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= SEED;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/color_dealer.sv
// color_dealer: deals one non-black ball colour and NUM_PLATS platform colours, one platform matching.
//   clk, reset (async, active-high) | req: start a deal (sampled in IDLE)
//   seed_load, seed_in: reseed the LFSR | busy, valid: deal in progress / complete
//   ball_color, plat_colors (slot k at [k*COLOR_W +: COLOR_W]), match_idx: the deal
//   Define DISTINCT_COLORS_EN to keep decoy platforms different from the ball colour.
module color_dealer import color_dealer_pkg::*; #(
    parameter int COLOR_W   = 3,
    parameter int NUM_PLATS = 4,
    parameter int LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED = LFSR_W'(16'hACE1),
    parameter int RETRY_MAX = 4,
    localparam int IDX_W = NUM_PLATS > 2 ? $clog2(NUM_PLATS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req,
    input  logic                           seed_load,
    input  logic [LFSR_W-1:0]              seed_in,
    output logic                           busy,
    output logic                           valid,
    output logic [COLOR_W-1:0]             ball_color,
    output logic [NUM_PLATS*COLOR_W-1:0]   plat_colors,
    output logic [IDX_W-1:0]               match_idx
);

    localparam int RET_W = RETRY_MAX > 0 ? $clog2(RETRY_MAX + 1) : 1;

    state_e                            state_q;
    logic [RET_W-1:0]                  retry_q;
    logic [IDX_W-1:0]                  slot_q, match_q, place_idx;
    logic [COLOR_W-1:0]                ball_q, cand, fallback;
    logic [NUM_PLATS-1:0][COLOR_W-1:0] plat_q;
    logic                              valid_q, exhausted, plat_ok, last_slot;
    logic [LFSR_W-1:0]                 lfsr;
    logic [IDX_W:0]                    idx_raw;
    logic                              unused_lfsr;

    lfsr_gen #(.LFSR_W(LFSR_W), .SEED(SEED)) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .load     (seed_load),
        .load_val (seed_in),
        .q        (lfsr)
    );

    assign unused_lfsr = ^lfsr;
    assign cand        = lfsr[COLOR_W-1:0];
    assign fallback    = COLOR_W'(fallback_color(32'(ball_q)));
    assign exhausted   = retry_q == RET_W'(RETRY_MAX);
    assign last_slot   = slot_q == IDX_W'(NUM_PLATS - 1);

    // Low index bits span at most 2*NUM_PLATS-1, so one subtraction folds them into range
    assign idx_raw   = {1'b0, lfsr[IDX_W-1:0]};
    assign place_idx = idx_raw >= (IDX_W+1)'(NUM_PLATS) ? IDX_W'(idx_raw - (IDX_W+1)'(NUM_PLATS))
                                                        : lfsr[IDX_W-1:0];

`ifdef DISTINCT_COLORS_EN
    assign plat_ok = cand != '0 && cand != ball_q;
    // Fallback colour 2 must be representable
    if (COLOR_W < 2) begin : g_color_w_check
        $error("DISTINCT_COLORS_EN requires COLOR_W >= 2");
    end
`else
    assign plat_ok = cand != '0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            retry_q <= '0;
            slot_q  <= '0;
            ball_q  <= '0;
            plat_q  <= '0;
            match_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req) begin
                    valid_q <= 1'b0;
                    state_q <= BALL;
                end
                BALL: if (cand != '0 || exhausted) begin
                    ball_q  <= cand != '0 ? cand : COLOR_W'(1);
                    retry_q <= '0;
                    slot_q  <= '0;
                    state_q <= PLATS;
                end else retry_q <= retry_q + RET_W'(1);
                PLATS: if (plat_ok || exhausted) begin
                    plat_q[slot_q] <= plat_ok ? cand : fallback;
                    retry_q        <= '0;
                    slot_q         <= slot_q + IDX_W'(1);
                    if (last_slot) state_q <= PLACE;
                end else retry_q <= retry_q + RET_W'(1);
                PLACE: begin
                    plat_q[place_idx] <= ball_q;
                    match_q           <= place_idx;
                    valid_q           <= 1'b1;
                    state_q           <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy        = state_q != IDLE;
    assign valid       = valid_q;
    assign ball_color  = ball_q;
    assign plat_colors = plat_q;
    assign match_idx   = match_q;

endmodule
